// File: rtl/lcd_result_display_pkg.sv
// Shared definitions for the mini-CPU display path: opcodes, LCD command
// bytes, ASCII constants and the FSM state/byte types.
package lcd_result_display_pkg;

    typedef enum logic [2:0] {
        OP_LOAD    = 3'd0,
        OP_ADD     = 3'd1,
        OP_ADDI    = 3'd2,
        OP_SUB     = 3'd3,
        OP_SUBI    = 3'd4,
        OP_MUL     = 3'd5,
        OP_CLEAR   = 3'd6,
        OP_DISPLAY = 3'd7
    } opcode_t;

    localparam logic [7:0] LCD_FUNC_SET = 8'h38;
    localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
    localparam logic [7:0] LCD_ENTRY    = 8'h06;
    localparam logic [7:0] LCD_CLEAR    = 8'h01;
    localparam logic [7:0] LCD_LINE1    = 8'h80;
    localparam logic [7:0] LCD_LINE2    = 8'hC0;

    localparam logic [7:0] ASCII_PLUS   = 8'h2B;
    localparam logic [7:0] ASCII_MINUS  = 8'h2D;
    localparam logic [7:0] ASCII_ZERO   = 8'h30;

    localparam logic [3:0] INIT_LAST    = 4'd3;
    localparam logic [3:0] FRAME_LAST   = 4'd11;

    typedef enum logic [2:0] {
        ST_PWRUP,
        ST_INIT,
        ST_IDLE,
        ST_CONVERT,
        ST_SETUP,
        ST_EHIGH,
        ST_WAIT
    } state_t;

    typedef struct packed {
        logic       rs;
        logic [7:0] data;
    } lcd_byte_t;

    function automatic logic [31:0] mnemonic(input logic [2:0] op);
        logic [31:0] m;
        m = "????";
        unique case (op)
            OP_LOAD:    m = "LOAD";
            OP_ADD:     m = "ADD ";
            OP_ADDI:    m = "ADDI";
            OP_SUB:     m = "SUB ";
            OP_SUBI:    m = "SUBI";
            OP_MUL:     m = "MUL ";
            OP_CLEAR:   m = "CLR ";
            OP_DISPLAY: m = "DISP";
        endcase
        return m;
    endfunction

endpackage

// File: rtl/lcd_result_display_bin2bcd.sv
// Sequential double-dabble: 16-bit unsigned binary to five BCD digits,
// one shift per cycle; done pulses after the sixteenth shift.
module bin2bcd_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        go,
    input  logic [15:0] bin,
    output logic        done,
    output logic [19:0] bcd
);

    logic [35:0] sr;
    logic [35:0] adj;
    logic [4:0]  cnt;
    logic        running;

    always_comb begin
        adj = sr;
        for (int i = 0; i < 5; i++) begin
            if (adj[16+4*i +: 4] >= 4'd5)
                adj[16+4*i +: 4] = adj[16+4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr      <= '0;
            cnt     <= '0;
            running <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (go) begin
                sr      <= {20'd0, bin};
                cnt     <= '0;
                running <= 1'b1;
            end else if (running) begin
                sr  <= {adj[34:0], 1'b0};
                cnt <= cnt + 5'd1;
                if (cnt == 5'd15) begin
                    running <= 1'b0;
                    done    <= 1'b1;
                end
            end
        end
    end

    assign bcd = sr[35:16];

endmodule

// File: rtl/lcd_result_display.sv
// HD44780 16x2 driver: power-up init, then one mnemonic/decimal frame
// per accepted start pulse.
module lcd_result_display
    import lcd_result_display_pkg::*;
#(
    parameter int unsigned T_PWRUP  = 1_000_000,
    parameter int unsigned T_EPULSE = 25,
    parameter int unsigned T_CMD    = 2_500,
    parameter int unsigned T_CLEAR  = 100_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  opcode,
    input  logic [15:0] value,
    output logic        busy,
    output logic        done,
    output logic        lcd_rs,
    output logic        lcd_rw,
    output logic        lcd_e,
    output logic [7:0]  lcd_data
);

    localparam int unsigned T_A   = (T_PWRUP > T_CLEAR) ? T_PWRUP : T_CLEAR;
    localparam int unsigned T_B   = (T_CMD > T_EPULSE) ? T_CMD : T_EPULSE;
    localparam int unsigned T_MAX = (T_A > T_B) ? T_A : T_B;
    localparam int          CW    = $clog2(T_MAX + 1);

    state_t      state, state_d;
    logic [CW-1:0] cnt, cnt_d, term;
    logic [3:0]  idx, idx_d;
    logic        in_init, in_init_d;
    logic [2:0]  op_q;
    logic        sign_q;
    lcd_byte_t   byte_q, nxt_byte;
    logic        frame_done;
    logic        bcd_go, bcd_done;
    logic [19:0] bcd;
    logic [15:0] mag;
    logic        hit;

    assign mag = value[15] ? 16'(~value + 16'd1) : value;

    bin2bcd_seq u_bcd (
        .clk  (clk),
        .rst  (rst),
        .go   (bcd_go),
        .bin  (mag),
        .done (bcd_done),
        .bcd  (bcd)
    );

    // The clear command needs the long settle time; all other bytes the short one.
    always_comb begin
        term = '0;
        unique case (state)
            ST_PWRUP: term = CW'(T_PWRUP - 1);
            ST_EHIGH: term = CW'(T_EPULSE - 1);
            ST_WAIT:  term = (!byte_q.rs && byte_q.data == LCD_CLEAR)
                           ? CW'(T_CLEAR - 1) : CW'(T_CMD - 1);
            default:  term = '0;
        endcase
    end

    assign hit = (cnt == term);

    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        idx_d      = idx;
        in_init_d  = in_init;
        frame_done = 1'b0;
        bcd_go     = 1'b0;
        unique case (state)
            ST_PWRUP: begin
                if (hit) begin
                    state_d = ST_INIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            ST_INIT: begin
                idx_d     = '0;
                in_init_d = 1'b1;
                state_d   = ST_SETUP;
            end
            ST_IDLE: begin
                if (start) begin
                    bcd_go  = 1'b1;
                    state_d = ST_CONVERT;
                end
            end
            ST_CONVERT: begin
                if (bcd_done) begin
                    idx_d     = '0;
                    in_init_d = 1'b0;
                    state_d   = ST_SETUP;
                end
            end
            ST_SETUP: begin
                cnt_d   = '0;
                state_d = ST_EHIGH;
            end
            ST_EHIGH: begin
                if (hit) begin
                    cnt_d   = '0;
                    state_d = ST_WAIT;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            ST_WAIT: begin
                if (!hit) begin
                    cnt_d = cnt + CW'(1);
                end else begin
                    cnt_d = '0;
                    if (idx == (in_init ? INIT_LAST : FRAME_LAST)) begin
                        frame_done = !in_init;
                        in_init_d  = 1'b0;
                        state_d    = ST_IDLE;
                    end else begin
                        idx_d   = idx + 4'd1;
                        state_d = ST_SETUP;
                    end
                end
            end
            default: state_d = ST_PWRUP;
        endcase
    end

    // Byte for the upcoming SETUP, selected from the next index.
    always_comb begin
        logic [31:0] m;
        int          mi;
        int          di;
        nxt_byte = '0;
        m  = mnemonic(op_q);
        mi = 8 * (4 - int'(idx_d));
        di = 4 * (11 - int'(idx_d));
        if (in_init_d) begin
            unique case (idx_d[1:0])
                2'd0: nxt_byte = '{1'b0, LCD_FUNC_SET};
                2'd1: nxt_byte = '{1'b0, LCD_DISP_ON};
                2'd2: nxt_byte = '{1'b0, LCD_ENTRY};
                2'd3: nxt_byte = '{1'b0, LCD_CLEAR};
            endcase
        end else begin
            unique case (1'b1)
                idx_d == 4'd0:
                    nxt_byte = '{1'b0, LCD_LINE1};
                idx_d >= 4'd1 && idx_d <= 4'd4:
                    nxt_byte = '{1'b1, m[mi +: 8]};
                idx_d == 4'd5:
                    nxt_byte = '{1'b0, LCD_LINE2};
                idx_d == 4'd6:
                    nxt_byte = '{1'b1, sign_q ? ASCII_MINUS : ASCII_PLUS};
                idx_d >= 4'd7 && idx_d <= 4'd11:
                    nxt_byte = '{1'b1, ASCII_ZERO | {4'd0, bcd[di +: 4]}};
                default:
                    nxt_byte = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_PWRUP;
            cnt     <= '0;
            idx     <= '0;
            in_init <= 1'b0;
            op_q    <= '0;
            sign_q  <= 1'b0;
            byte_q  <= '0;
            lcd_e   <= 1'b0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            idx     <= idx_d;
            in_init <= in_init_d;
            if (state == ST_IDLE && start) begin
                op_q   <= opcode;
                sign_q <= value[15];
            end
            if (state_d == ST_SETUP)
                byte_q <= nxt_byte;
            lcd_e <= (state_d == ST_EHIGH);
        end
    end

    assign busy     = (state != ST_IDLE);
    assign done     = frame_done;
    assign lcd_rs   = byte_q.rs;
    assign lcd_data = byte_q.data;
    assign lcd_rw   = 1'b0;

endmodule
